// File: rtl/mpmc10_app_cmd_seq_if.sv
// Burst-request, write-credit and memory application command signals shared by
// the command sequencer and its environment.
interface mpmc10_app_cmd_seq_if #(
  parameter int ADDR_W = 29,
  parameter int LEN_W  = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wdata_beat;
  logic              app_rdy;
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic              busy;
  logic              done;
  logic              credit_err;

  modport master (
    input  req_valid, req_we, req_addr, req_len, wdata_beat, app_rdy,
    output req_ready, app_en, app_cmd, app_addr, busy, done, credit_err
  );

  modport slave (
    output req_valid, req_we, req_addr, req_len, wdata_beat, app_rdy,
    input  req_ready, app_en, app_cmd, app_addr, busy, done, credit_err
  );
endinterface

// File: rtl/mpmc10_app_cmd_seq.sv
// Splits a burst request into req_len+1 application commands at STRIDE spacing;
// write commands are only presented when write-data credit is available.
module mpmc10_app_cmd_seq #(
  parameter int         ADDR_W    = 29,
  parameter int         LEN_W     = 6,
  parameter int         STRIDE    = 8,
  parameter logic [2:0] CMD_WRITE = 3'b000,
  parameter logic [2:0] CMD_READ  = 3'b001
) (
  input logic                   clk,
  input logic                   rst_n,
  mpmc10_app_cmd_seq_if.master  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;
  localparam int         CW       = LEN_W + 1;

  logic [1:0]        state_q, state_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              we_q, we_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic              err_q, err_d;
  logic              ovf;
  logic              issue, consume;

  // Returns {overflow, next credit}; a beat at full credit saturates and flags.
  function automatic logic [CW:0] credit_next(input logic [CW-1:0] c,
                                              input logic beat, input logic use_c);
    if (beat && !use_c) begin
      if (&c) return {1'b1, c};
      return {1'b0, c + CW'(1)};
    end
    if (!beat && use_c) return {1'b0, c - CW'(1)};
    return {1'b0, c};
  endfunction

  assign issue   = (state_q == S_ISSUE);
  assign consume = issue && bus.app_rdy && we_q;

  always_comb begin
    {ovf, credit_d} = credit_next(credit_q, bus.wdata_beat, consume);
    err_d   = err_q | ovf;
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    we_d    = we_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          rem_d   = bus.req_len;
          cmd_d   = bus.req_we ? CMD_WRITE : CMD_READ;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!we_q || credit_q != '0 || bus.wdata_beat) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (bus.app_rdy) begin
          if (rem_q == '0) begin
            state_d = S_FINISH;
          end else begin
            rem_d  = rem_q - LEN_W'(1);
            addr_d = addr_q + ADDR_W'(STRIDE);
            // Writes pause until the next beat once the credit is used up.
            if (we_q && credit_d == '0) state_d = S_WAIT;
          end
        end
      end
      default: begin
        cmd_d   = CMD_WRITE;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cmd_q    <= CMD_WRITE;
      addr_q   <= '0;
      credit_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  // Burst bookkeeping is always written before use, so it carries no reset.
  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    we_q  <= we_d;
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.app_en     = issue;
  assign bus.app_cmd    = cmd_q;
  assign bus.app_addr   = addr_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_FINISH);
  assign bus.credit_err = err_q;

endmodule

// File: tb/tb_mpmc10_app_cmd_seq.sv
// Directed bench for the application command sequencer.
module tb_mpmc10_app_cmd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   acc_cnt = 0;
  int   acc_base;

  mpmc10_app_cmd_seq_if #(.ADDR_W(29), .LEN_W(6)) bus ();

  mpmc10_app_cmd_seq #(
    .ADDR_W(29), .LEN_W(6), .STRIDE(8), .CMD_WRITE(3'b000), .CMD_READ(3'b001)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.app_en && bus.app_rdy) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic we, input logic [28:0] addr, input logic [5:0] len);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_len   = len;
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_len    = '0;
    bus.wdata_beat = 1'b0;
    bus.app_rdy    = 1'b0;

    // Reset state
    #3;
    chk("rst_app_en", bus.app_en, 0);
    chk("rst_app_cmd", bus.app_cmd, 3'b000);
    chk("rst_app_addr", bus.app_addr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_credit_err", bus.credit_err, 0);
    chk("rst_credit", dut.credit_q, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_req_ready", bus.req_ready, 1);

    // Read burst, back-to-back
    bus.app_rdy = 1'b1;
    request(1'b0, 29'h100, 6'd3);
    chk("rd_busy", bus.busy, 1);
    chk("rd_ready_low", bus.req_ready, 0);
    chk("rd_wait_en", bus.app_en, 0);
    chk("rd_cmd_early", bus.app_cmd, 3'b001);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("rd_en", bus.app_en, 1);
      chk("rd_addr", bus.app_addr, 64'h100 + 64'(8 * i));
      chk("rd_cmd", bus.app_cmd, 3'b001);
      chk("rd_no_done", bus.done, 0);
      tick();
    end
    chk("rd_en_off", bus.app_en, 0);
    chk("rd_done", bus.done, 1);
    tick();
    chk("rd_done_once", bus.done, 0);
    chk("rd_idle_cmd", bus.app_cmd, 3'b000);
    chk("rd_idle_busy", bus.busy, 0);

    // Write burst gated by data beats
    request(1'b1, 29'h2000, 6'd1);
    chk("wr_cmd", bus.app_cmd, 3'b000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wr_no_credit", bus.app_en, 0);
    end
    bus.wdata_beat = 1'b1;
    tick();
    bus.wdata_beat = 1'b0;
    chk("wr_en1", bus.app_en, 1);
    chk("wr_addr1", bus.app_addr, 64'h2000);
    tick();
    chk("wr_en_drop", bus.app_en, 0);
    tick();
    chk("wr_still_wait", bus.app_en, 0);
    tick();
    bus.wdata_beat = 1'b1;
    tick();
    bus.wdata_beat = 1'b0;
    chk("wr_en2", bus.app_en, 1);
    chk("wr_addr2", bus.app_addr, 64'h2008);
    tick();
    chk("wr_done", bus.done, 1);
    tick();
    chk("wr_credit0", dut.credit_q, 0);

    // Stall with app_rdy low
    bus.app_rdy = 1'b0;
    request(1'b0, 29'h400, 6'd1);
    tick();
    acc_base = acc_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("st_en", bus.app_en, 1);
      chk("st_addr", bus.app_addr, 64'h400);
      chk("st_cmd", bus.app_cmd, 3'b001);
      tick();
    end
    bus.app_rdy = 1'b1;
    chk("st_hold", bus.app_addr, 64'h400);
    tick();
    chk("st_addr2", bus.app_addr, 64'h408);
    tick();
    chk("st_done", bus.done, 1);
    chk("st_accepts", acc_cnt - acc_base, 2);
    tick();

    // Address wrap
    request(1'b0, 29'h1FFFFFF8, 6'd1);
    tick();
    chk("wrap_a0", bus.app_addr, 64'h1FFFFFF8);
    tick();
    chk("wrap_a1", bus.app_addr, 64'h0);
    chk("wrap_en", bus.app_en, 1);
    tick();
    chk("wrap_done", bus.done, 1);
    tick();

    // Credit carry-over and simultaneous beat + consume
    bus.wdata_beat = 1'b1;
    tick();
    bus.wdata_beat = 1'b0;
    chk("cr_early", dut.credit_q, 1);
    request(1'b1, 29'h3000, 6'd0);
    tick();
    chk("cr_issue", bus.app_en, 1);
    bus.wdata_beat = 1'b1;
    tick();
    bus.wdata_beat = 1'b0;
    chk("cr_both", dut.credit_q, 1);
    chk("cr_done", bus.done, 1);
    tick();
    request(1'b1, 29'h3100, 6'd0);
    tick();
    tick();
    chk("cr_drained", dut.credit_q, 0);
    tick();

    // Credit saturation
    bus.wdata_beat = 1'b1;
    for (int i = 0; i < 127; i++) tick();
    chk("sat_127", dut.credit_q, 127);
    chk("sat_no_err", bus.credit_err, 0);
    tick();
    bus.wdata_beat = 1'b0;
    chk("sat_hold", dut.credit_q, 127);
    chk("sat_err", bus.credit_err, 1);
    tick();
    chk("sat_sticky", bus.credit_err, 1);

    // Reset mid-burst
    request(1'b0, 29'h500, 6'd3);
    tick();
    tick();
    chk("mr_addr", bus.app_addr, 64'h508);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_en", bus.app_en, 0);
    chk("mr_cmd", bus.app_cmd, 3'b000);
    chk("mr_busy", bus.busy, 0);
    chk("mr_credit", dut.credit_q, 0);
    chk("mr_err", bus.credit_err, 0);
    chk("mr_addr0", bus.app_addr, 0);
    tick();
    chk("mr_no_done", bus.done, 0);
    rst_n = 1'b1;
    tick();
    chk("mr_ready", bus.req_ready, 1);
    request(1'b0, 29'h600, 6'd0);
    chk("mr_busy2", bus.busy, 1);
    tick();
    chk("mr_en2", bus.app_en, 1);
    chk("mr_addr2", bus.app_addr, 64'h600);
    tick();
    chk("mr_done2", bus.done, 1);
    tick();
    chk("mr_idle", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
